// File: rtl/bldc_commutator.sv
// rtl/bldc_commutator.sv - six-step BLDC commutation controller with open-loop start and Hall lock
// Optional: define BLDC_DEADTIME_EN to blank all gates for DEADTIME cycles at every sector change.
module bldc_commutator #(
    parameter int PWM_W        = 8,
    parameter int PERIOD_W     = 24,
    parameter int STEP_W       = 24,
    parameter int ALIGN_CYCLES = 50000,
    parameter int START_STEP   = 200000,
    parameter int MIN_STEP     = 20000,
    parameter int RAMP_DEC     = 10000,
    parameter int LOCK_EDGES   = 6,
    parameter int STALL_CYCLES = 2500000,
    parameter int DEADTIME     = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                dir,
    input  logic [PWM_W-1:0]    duty,
    input  logic [2:0]          hall,
    output logic                hin_r,
    output logic                hin_s,
    output logic                hin_t,
    output logic                lin_n_r,
    output logic                lin_n_s,
    output logic                lin_n_t,
    output logic [2:0]          sector,
    output logic [2:0]          state,
    output logic [PERIOD_W-1:0] hall_period,
    output logic                period_valid,
    output logic                fault
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALIGN  = 3'd1;
    localparam logic [2:0] S_OPEN   = 3'd2;
    localparam logic [2:0] S_CLOSED = 3'd3;
    localparam logic [2:0] S_FAULT  = 3'd4;

    localparam int LOCK_W = $clog2(LOCK_EDGES + 1);
    localparam int DT_W   = $clog2(DEADTIME + 2);
`ifdef BLDC_DEADTIME_EN
    localparam int DT_LEN = DEADTIME;
`else
    localparam int DT_LEN = 0;
`endif

    // Hall code to sector; CW and CCW tables differ because the field rotates the other way.
    function automatic logic [2:0] f_map(input logic [2:0] h, input logic cw);
        logic [2:0] s;
        s = 3'd0;
        if (cw) begin
            case (h)
                3'd1: s = 3'd4;
                3'd2: s = 3'd0;
                3'd3: s = 3'd5;
                3'd4: s = 3'd2;
                3'd5: s = 3'd3;
                3'd6: s = 3'd1;
                default: s = 3'd0;
            endcase
        end else begin
            case (h)
                3'd1: s = 3'd1;
                3'd2: s = 3'd3;
                3'd3: s = 3'd2;
                3'd4: s = 3'd5;
                3'd5: s = 3'd0;
                3'd6: s = 3'd4;
                default: s = 3'd0;
            endcase
        end
        return s;
    endfunction

    function automatic logic [2:0] f_adv(input logic [2:0] s, input logic cw);
        logic [2:0] n;
        if (cw) n = (s == 3'd5) ? 3'd0 : s + 3'd1;
        else    n = (s == 3'd0) ? 3'd5 : s - 3'd1;
        return n;
    endfunction

    // One-hot {T,S,R} of the phase driven high in a sector.
    function automatic logic [2:0] f_high(input logic [2:0] s);
        logic [2:0] p;
        case (s)
            3'd0, 3'd1: p = 3'b001;
            3'd2, 3'd3: p = 3'b010;
            default:    p = 3'b100;
        endcase
        return p;
    endfunction

    // One-hot {T,S,R} of the phase pulled low in a sector.
    function automatic logic [2:0] f_low(input logic [2:0] s);
        logic [2:0] p;
        case (s)
            3'd0:       p = 3'b010;
            3'd1, 3'd2: p = 3'b100;
            3'd3, 3'd4: p = 3'b001;
            default:    p = 3'b010;
        endcase
        return p;
    endfunction

    logic [2:0]          r_hall_s1;
    logic [2:0]          r_hall_s2;
    logic [2:0]          r_hall_prev;
    logic [2:0]          r_prev_map;
    logic                r_prev_map_vld;
    logic                r_illegal_q;
    logic [2:0]          r_state;
    logic [2:0]          r_sector;
    logic [STEP_W-1:0]   r_step_cnt;
    logic [STEP_W-1:0]   r_step_int;
    logic [LOCK_W-1:0]   r_lock_cnt;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [PERIOD_W-1:0] r_hall_period;
    logic                r_period_valid;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [DT_W-1:0]     r_dt_cnt;
    logic [2:0]          r_hin;
    logic [2:0]          r_lin_n;

    logic                w_legal;
    logic                w_edge;
    logic [2:0]          w_map;
    logic                w_in_seq;
    logic [2:0]          w_state_nxt;
    logic [2:0]          w_sector_nxt;
    logic [STEP_W-1:0]   w_step_cnt_nxt;
    logic [STEP_W-1:0]   w_step_int_nxt;
    logic [LOCK_W-1:0]   w_lock_nxt;
    logic [PERIOD_W-1:0] w_period_cnt_nxt;
    logic [PERIOD_W-1:0] w_hall_period_nxt;
    logic                w_period_valid_nxt;
    logic                w_drive;
    logic [2:0]          w_hin_pat;
    logic [2:0]          w_lin_n_pat;

    assign w_legal  = (r_hall_s2 != 3'd0) && (r_hall_s2 != 3'd7);
    assign w_edge   = (r_hall_s2 != r_hall_prev);
    assign w_map    = f_map(r_hall_s2, dir);
    assign w_in_seq = w_edge && w_legal && r_prev_map_vld && (w_map == f_adv(r_prev_map, dir));

    // Hall synchroniser, edge history, last mapped sector and free-running PWM counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hall_s1      <= 3'd0;
            r_hall_s2      <= 3'd0;
            r_hall_prev    <= 3'd0;
            r_prev_map     <= 3'd0;
            r_prev_map_vld <= 1'b0;
            r_illegal_q    <= 1'b0;
            r_pwm_cnt      <= '0;
        end else begin
            r_hall_s1   <= hall;
            r_hall_s2   <= r_hall_s1;
            r_hall_prev <= r_hall_s2;
            r_illegal_q <= !w_legal;
            r_pwm_cnt   <= r_pwm_cnt + PWM_W'(1);
            if (w_edge) begin
                r_prev_map     <= w_map;
                r_prev_map_vld <= w_legal;
            end
        end
    end

    // Next-state logic: start-up sequence, lock detection, period measurement and fault checks.
    always_comb begin
        w_state_nxt        = r_state;
        w_sector_nxt       = r_sector;
        w_step_cnt_nxt     = r_step_cnt;
        w_step_int_nxt     = r_step_int;
        w_lock_nxt         = r_lock_cnt;
        w_period_cnt_nxt   = r_period_cnt;
        w_hall_period_nxt  = r_hall_period;
        w_period_valid_nxt = 1'b0;
        if (!en) begin
            w_state_nxt      = S_IDLE;
            w_sector_nxt     = 3'd0;
            w_step_cnt_nxt   = '0;
            w_step_int_nxt   = STEP_W'(START_STEP);
            w_lock_nxt       = '0;
            w_period_cnt_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt    = S_ALIGN;
                    w_sector_nxt   = 3'd0;
                    w_step_cnt_nxt = '0;
                end
                S_ALIGN: begin
                    w_sector_nxt = 3'd0;
                    if (r_step_cnt == STEP_W'(ALIGN_CYCLES - 1)) begin
                        w_state_nxt    = S_OPEN;
                        w_step_cnt_nxt = '0;
                        w_step_int_nxt = STEP_W'(START_STEP);
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + STEP_W'(1);
                    end
                end
                S_OPEN: begin
                    if (r_step_cnt == r_step_int - STEP_W'(1)) begin
                        w_sector_nxt   = f_adv(r_sector, dir);
                        w_step_cnt_nxt = '0;
                        w_step_int_nxt = (r_step_int > STEP_W'(MIN_STEP + RAMP_DEC))
                                       ? r_step_int - STEP_W'(RAMP_DEC) : STEP_W'(MIN_STEP);
                    end else begin
                        w_step_cnt_nxt = r_step_cnt + STEP_W'(1);
                    end
                    if (w_edge) begin
                        w_lock_nxt = w_in_seq ? r_lock_cnt + LOCK_W'(1) : '0;
                    end
                    if (w_in_seq && (r_lock_cnt + LOCK_W'(1) == LOCK_W'(LOCK_EDGES))) begin
                        w_state_nxt      = S_CLOSED;
                        w_sector_nxt     = w_map;
                        w_lock_nxt       = '0;
                        w_period_cnt_nxt = PERIOD_W'(1);
                    end
                end
                S_CLOSED: begin
                    if (w_legal) begin
                        w_sector_nxt = w_map;
                    end
                    if (w_edge && w_legal) begin
                        w_hall_period_nxt  = r_period_cnt;
                        w_period_valid_nxt = 1'b1;
                        w_period_cnt_nxt   = PERIOD_W'(1);
                    end else if (r_period_cnt != {PERIOD_W{1'b1}}) begin
                        w_period_cnt_nxt = r_period_cnt + PERIOD_W'(1);
                    end
                    if (!(w_edge && w_legal) && (r_period_cnt == PERIOD_W'(STALL_CYCLES))) begin
                        w_state_nxt = S_FAULT;
                    end
                    if (!w_legal && r_illegal_q) begin
                        w_state_nxt = S_FAULT;
                    end
                end
                S_FAULT: begin
                    w_state_nxt = S_FAULT;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_sector       <= 3'd0;
            r_step_cnt     <= '0;
            r_step_int     <= STEP_W'(START_STEP);
            r_lock_cnt     <= '0;
            r_period_cnt   <= '0;
            r_hall_period  <= '0;
            r_period_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_sector       <= w_sector_nxt;
            r_step_cnt     <= w_step_cnt_nxt;
            r_step_int     <= w_step_int_nxt;
            r_lock_cnt     <= w_lock_nxt;
            r_period_cnt   <= w_period_cnt_nxt;
            r_hall_period  <= w_hall_period_nxt;
            r_period_valid <= w_period_valid_nxt;
        end
    end

    // Gate pattern for the upcoming sector; the lower switch is chopped by the PWM compare.
    assign w_drive     = (w_state_nxt == S_ALIGN) || (w_state_nxt == S_OPEN) || (w_state_nxt == S_CLOSED);
    assign w_hin_pat   = w_drive ? f_high(w_sector_nxt) : 3'b000;
    assign w_lin_n_pat = (w_drive && (r_pwm_cnt < duty)) ? ~f_low(w_sector_nxt) : 3'b111;

    // Gate registers; a sector change opens an all-off window when DT_LEN is non-zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dt_cnt <= '0;
            r_hin    <= 3'b000;
            r_lin_n  <= 3'b111;
        end else if ((DT_LEN != 0) && (w_sector_nxt != r_sector)) begin
            r_dt_cnt <= DT_W'(DT_LEN);
            r_hin    <= 3'b000;
            r_lin_n  <= 3'b111;
        end else if (r_dt_cnt > DT_W'(1)) begin
            r_dt_cnt <= r_dt_cnt - DT_W'(1);
            r_hin    <= 3'b000;
            r_lin_n  <= 3'b111;
        end else begin
            r_dt_cnt <= '0;
            r_hin    <= w_hin_pat;
            r_lin_n  <= w_lin_n_pat;
        end
    end

    assign hin_r        = r_hin[0];
    assign hin_s        = r_hin[1];
    assign hin_t        = r_hin[2];
    assign lin_n_r      = r_lin_n[0];
    assign lin_n_s      = r_lin_n[1];
    assign lin_n_t      = r_lin_n[2];
    assign sector       = r_sector;
    assign state        = r_state;
    assign hall_period  = r_hall_period;
    assign period_valid = r_period_valid;
    assign fault        = (r_state == S_FAULT);

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Parametrised six-step BLDC commutation controller for one three-phase inverter. It runs an align / open-loop ramp start, then locks to the Hall sensors, and supports both directions. It chops the lower arm with a PWM duty of configurable width, measures the Hall edge interval and faults on a stall or an illegal Hall code. It sits between the throttle/ADC logic, which supplies `duty`, and the gate-driver pins, and it supplies `hall_period` to the CAN telemetry path.

## Interface
- `PWM_W`, 8: duty and PWM counter width.
- `PERIOD_W`, 24: Hall interval counter width; requires `STALL_CYCLES < 2**PERIOD_W`.
- `STEP_W`, 24: open-loop step counter width.
- `ALIGN_CYCLES`, 50000: cycles held in sector 0 during ALIGN.
- `START_STEP`, 200000: first open-loop step interval, in cycles.
- `MIN_STEP`, 20000: floor of the open-loop step interval.
- `RAMP_DEC`, 10000: step-interval decrement applied per open-loop step.
- `LOCK_EDGES`, 6: consecutive in-sequence Hall edges needed to enter CLOSED_LOOP.
- `STALL_CYCLES`, 2500000: edge-free cycles in CLOSED_LOOP that raise a fault.
- `DEADTIME`, 25: cycles with all switches off at each sector change.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run request. Low forces IDLE.
- `dir` in 1: 1 = CW, 0 = CCW. Sampled every cycle.
- `duty` in `PWM_W`: on-time in PWM counts.
- `hall` in 3: raw asynchronous Hall inputs.
- `hin_r`, `hin_s`, `hin_t` out 1 each: upper-arm gates, active high.
- `lin_n_r`, `lin_n_s`, `lin_n_t` out 1 each: lower-arm gates, active low.
- `sector` out 3: current commutation sector, 0–5.
- `state` out 3: IDLE=0, ALIGN=1, OPEN_LOOP=2, CLOSED_LOOP=3, FAULT=4.
- `hall_period` out `PERIOD_W`: cycles between the last two Hall edges.
- `period_valid` out 1: one-cycle strobe when `hall_period` updates.
- `fault` out 1: high while in FAULT.

## Operation
- Reset values: all `hin_*`=0, all `lin_n_*`=1, `sector`=0, `state`=IDLE, `hall_period`=0, `period_valid`=0, `fault`=0.
- Hall inputs pass a 2-flop synchroniser. An edge is a synchronised value that differs from its previous registered value. Codes 000 and 111 are illegal.
- CW Hall→sector map: 1→4, 2→0, 3→5, 4→2, 5→3, 6→1.
- CCW Hall→sector map: 1→1, 2→3, 3→2, 4→5, 5→0, 6→4.
- Sector drive, as (high phase, low phase): 0 (R,S), 1 (R,T), 2 (S,T), 3 (S,R), 4 (T,R), 5 (T,S). The third phase has both switches off.
- PWM: a free-running `PWM_W` counter wraps at 2**`PWM_W`−1. The selected lower switch is on only while the counter < `duty`; the upper switch stays on for the whole sector. `duty`=0 turns the lower switch fully off. The all-ones `duty` gives (2**W−1)/2**W on-time.
- IDLE: all switches off. `en`=1 → ALIGN.
- ALIGN: sector 0 is driven for `ALIGN_CYCLES` cycles, then → OPEN_LOOP with interval = `START_STEP`.
- OPEN_LOOP:
  - Each time the step counter reaches the interval, `sector` advances by 1 mod 6 (CW) or by 5 mod 6 (CCW).
  - Each step also sets interval = max(interval−`RAMP_DEC`, `MIN_STEP`).
  - A Hall edge whose mapped sector equals the previous mapped sector advanced one step in `dir` increments the lock count. Any other edge clears the count.
  - Lock count = `LOCK_EDGES` → CLOSED_LOOP, with `sector` taken from the Hall map.
  - Illegal codes do not fault in OPEN_LOOP; they clear the lock count.
- CLOSED_LOOP:
  - `sector` follows the Hall map.
  - On each edge, `hall_period` ← the interval counter, `period_valid` pulses, and the counter restarts at 1. The counter saturates at its maximum.
  - Counter = `STALL_CYCLES` → FAULT.
  - An illegal code seen on 2 consecutive synchronised samples → FAULT.
- FAULT: all switches off and `fault`=1. Exits only when `en`=0, going to IDLE.
- `en`=0 in any state → IDLE on the next edge, which clears the lock count and the counters. This takes priority over a same-cycle fault or lock.
- A `dir` change in CLOSED_LOOP takes effect on the next Hall-map evaluation. In OPEN_LOOP it applies from the next step.

## Timing
- A `hall` change at edge N is visible on synchronised Hall at N+2. `sector` and the gate outputs update at N+3 (no deadtime) and `period_valid` pulses in cycle N+3.
- The gate outputs are registered. A `duty` change takes effect at the next PWM counter compare.
- `rst` mid-operation returns every output to its reset value on the next edge.

## Configuration
- `BLDC_DEADTIME_EN` defined:
  - Every `sector` change forces all six gates off (`hin_*`=0, `lin_n_*`=1) for `DEADTIME` cycles.
  - The new pattern appears after that window; with a Hall change at N, the new pattern appears at N+3+`DEADTIME`.
  - A further sector change inside the window restarts the window.
- `BLDC_DEADTIME_EN` undefined: gates switch directly to the new pattern.

## Test plan
Bench parameters: `ALIGN_CYCLES`=10, `START_STEP`=100, `MIN_STEP`=40, `RAMP_DEC`=20, `LOCK_EDGES`=3, `STALL_CYCLES`=500, `DEADTIME`=4, `PWM_W`=4.

1. Reset, then `en`=1, `duty`=8 → ALIGN lasts 10 cycles. `hin_r`=1 and `lin_n_s` is low for 8 of every 16 cycles. Open-loop step intervals are 100, 80, 60, 40, 40.
2. In OPEN_LOOP CW, drive Hall 2→6→4 (sectors 0→1→2) → state=3 at the 3rd edge+3. A Hall change to 5 at edge N gives `sector`=3 at N+3.
3. In CLOSED_LOOP, apply Hall edges 200 cycles apart → `hall_period`=200 with a 1-cycle `period_valid`. After 500 edge-free cycles, `fault`=1 and all gates are off.
4. Hold Hall=111 for 2 synchronised samples in CLOSED_LOOP → FAULT. With `en`=0, state is IDLE next cycle.
5. With `dir`=0 and Hall=1 → `sector`=1 (drive R high, T low). With `duty`=0, all `lin_n_*` stay 1.
6. With `BLDC_DEADTIME_EN` defined, a sector change gives exactly 4 cycles of all-off before the new pattern. Asserting `rst` mid-deadtime gives reset values next cycle.
